// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: player-input front end for tetris_grid.
// Turns joystick ADC samples into a CENTER/LEFT/RIGHT direction with
// hysteresis, and debounces the two pushbuttons. It produces single-cycle
// move/rotate pulses, with DAS/ARR auto-repeat for horizontal moves and
// soft drop.
//
// Optional feature: define TETRIS_COMBO_RESET_EN to build the both-buttons
// combo reset. When it is enabled, rotate/move_down are suppressed while
// both buttons are held.
//
// Ports:
//   clk          system clock (50 MHz)
//   reset        synchronous active-high reset
//   adc_value    latest joystick sample
//   adc_valid    one-cycle strobe qualifying adc_value
//   btn_raw      asynchronous button levels, [0]=rotate, [1]=down
//   move_left    one-cycle move-left pulse
//   move_right   one-cycle move-right pulse
//   move_down    one-cycle soft-drop pulse
//   rotate       one-cycle rotate pulse
//   dir_state    00=CENTER, 01=LEFT, 10=RIGHT
//   btn_level    debounced button levels
//   combo_reset  one-cycle game-reset request (0 unless the feature is built)
module tetris_input_ctrl #(
    parameter int unsigned ADC_W           = 12,
    parameter int unsigned HI_THRESH       = 2000,
    parameter int unsigned LO_THRESH       = 1300,
    parameter int unsigned HYST            = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DAS_CYCLES      = 8000000,
    parameter int unsigned ARR_CYCLES      = 2500000,
    parameter int unsigned COMBO_CYCLES    = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_value,
    input  logic             adc_valid,
    input  logic [1:0]       btn_raw,
    output logic             move_left,
    output logic             move_right,
    output logic             move_down,
    output logic             rotate,
    output logic [1:0]       dir_state,
    output logic [1:0]       btn_level,
    output logic             combo_reset
);

    localparam logic [1:0] ST_CENTER = 2'b00;
    localparam logic [1:0] ST_LEFT   = 2'b01;
    localparam logic [1:0] ST_RIGHT  = 2'b10;

    // One extra bit so threshold +/- HYST cannot wrap.
    localparam int unsigned   CMP_W    = ADC_W + 1;
    localparam logic [CMP_W-1:0] HI_ENTRY = CMP_W'(HI_THRESH);
    localparam logic [CMP_W-1:0] LO_ENTRY = CMP_W'(LO_THRESH);
    localparam logic [CMP_W-1:0] HI_EXIT  = CMP_W'(HI_THRESH - HYST);
    localparam logic [CMP_W-1:0] LO_EXIT  = CMP_W'(LO_THRESH + HYST);

    localparam int unsigned RPT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DAS_LAST = RPT_W'(DAS_CYCLES - 1);
    localparam logic [RPT_W-1:0] ARR_LAST = RPT_W'(ARR_CYCLES - 1);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    // Zero-length timing parameters would make terminal counts wrap.
    if (DAS_CYCLES == 0 || ARR_CYCLES == 0 || DEBOUNCE_CYCLES == 0 || COMBO_CYCLES == 0) begin : g_bad_params
        $error("tetris_input_ctrl: cycle-count parameters must be non-zero");
    end

    // Repeat counter terminal: DAS delay first, ARR period afterwards.
    function automatic logic rpt_done(input logic [RPT_W-1:0] cnt, input logic arr);
        return arr ? (cnt == ARR_LAST) : (cnt == DAS_LAST);
    endfunction

    // ------------------------------------------------------------------
    // Direction FSM
    // ------------------------------------------------------------------
    logic [CMP_W-1:0] adc_x;
    logic [1:0]       dir_next;
    logic [RPT_W-1:0] h_cnt;
    logic             h_arr;

    assign adc_x = {1'b0, adc_value};

    // Next direction; only a strobed sample may move the state.
    always_comb begin
        dir_next = dir_state;
        if (adc_valid) begin
            case (dir_state)
                ST_CENTER: begin
                    if (adc_x > HI_ENTRY)      dir_next = ST_RIGHT;
                    else if (adc_x < LO_ENTRY) dir_next = ST_LEFT;
                end
                ST_RIGHT: begin
                    if (adc_x < LO_ENTRY)      dir_next = ST_LEFT;
                    else if (adc_x < HI_EXIT)  dir_next = ST_CENTER;
                end
                ST_LEFT: begin
                    if (adc_x > HI_ENTRY)      dir_next = ST_RIGHT;
                    else if (adc_x > LO_EXIT)  dir_next = ST_CENTER;
                end
                default: dir_next = ST_CENTER;
            endcase
        end
    end

    // State register plus horizontal pulse / auto-repeat.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_state  <= ST_CENTER;
            h_cnt      <= '0;
            h_arr      <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
        end else begin
            dir_state  <= dir_next;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            if (dir_next != dir_state) begin
                // Entry (or direct swap) pulses immediately and restarts DAS.
                move_left  <= (dir_next == ST_LEFT);
                move_right <= (dir_next == ST_RIGHT);
                h_cnt      <= '0;
                h_arr      <= 1'b0;
            end else if (dir_state == ST_CENTER) begin
                h_cnt <= '0;
                h_arr <= 1'b0;
            end else if (rpt_done(h_cnt, h_arr)) begin
                move_left  <= (dir_state == ST_LEFT);
                move_right <= (dir_state == ST_RIGHT);
                h_cnt      <= '0;
                h_arr      <= 1'b1;
            end else begin
                h_cnt <= h_cnt + RPT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Button synchroniser and debounce
    // ------------------------------------------------------------------
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       btn_prev;
    logic [1:0]       btn_rise;
    logic [DEB_W-1:0] deb_cnt [2];

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any return to agreement restarts the stability window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a    <= 2'b00;
            sync_b    <= 2'b00;
            btn_level <= 2'b00;
            btn_prev  <= 2'b00;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync_a   <= btn_raw;
            sync_b   <= sync_a;
            btn_prev <= btn_level;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == btn_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    btn_level[i] <= sync_b[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign btn_rise = btn_level & ~btn_prev;

    // ------------------------------------------------------------------
    // Optional combo reset
    // ------------------------------------------------------------------
    logic pulse_block;

`ifdef TETRIS_COMBO_RESET_EN
    localparam int unsigned COMBO_W = $clog2(COMBO_CYCLES + 1);
    localparam logic [COMBO_W-1:0] COMBO_LAST = COMBO_W'(COMBO_CYCLES - 1);

    logic [COMBO_W-1:0] combo_cnt;
    logic               combo_done;

    assign pulse_block = &btn_level;

    // Counts while both are held, fires once, then waits for a release.
    always_ff @(posedge clk) begin
        if (reset) begin
            combo_cnt   <= '0;
            combo_done  <= 1'b0;
            combo_reset <= 1'b0;
        end else begin
            combo_reset <= 1'b0;
            if (!pulse_block) begin
                combo_cnt  <= '0;
                combo_done <= 1'b0;
            end else if (combo_cnt == COMBO_LAST) begin
                if (!combo_done) begin
                    combo_reset <= 1'b1;
                    combo_done  <= 1'b1;
                end
            end else begin
                combo_cnt <= combo_cnt + COMBO_W'(1);
            end
        end
    end
`else
    assign pulse_block = 1'b0;
    assign combo_reset = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Rotate and soft drop
    // ------------------------------------------------------------------
    logic [RPT_W-1:0] d_cnt;
    logic             d_arr;

    // Rotate never repeats; soft drop reuses the DAS/ARR scheme.
    always_ff @(posedge clk) begin
        if (reset) begin
            rotate    <= 1'b0;
            move_down <= 1'b0;
            d_cnt     <= '0;
            d_arr     <= 1'b0;
        end else begin
            rotate    <= btn_rise[0] & ~pulse_block;
            move_down <= 1'b0;
            if (!btn_level[1]) begin
                d_cnt <= '0;
                d_arr <= 1'b0;
            end else if (btn_rise[1]) begin
                move_down <= ~pulse_block;
                d_cnt     <= '0;
                d_arr     <= 1'b0;
            end else if (rpt_done(d_cnt, d_arr)) begin
                move_down <= ~pulse_block;
                d_cnt     <= '0;
                d_arr     <= 1'b1;
            end else begin
                d_cnt <= d_cnt + RPT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Scoreboard bench for tetris_input_ctrl: expected pulse cycles are queued
// when stimulus is applied and matched against pulses seen on the outputs.
module tb_tetris_input_ctrl;

    localparam int unsigned ADC_W = 12;
    localparam int DAS = 8;
    localparam int ARR = 3;

    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_DOWN  = 2;
    localparam int K_ROT   = 3;
    localparam int K_COMBO = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [ADC_W-1:0] adc_value;
    logic             adc_valid;
    logic [1:0]       btn_raw;
    logic             move_left, move_right, move_down, rotate, combo_reset;
    logic [1:0]       dir_state, btn_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    int q_left[$];
    int q_right[$];
    int q_down[$];
    int q_rot[$];
    int q_combo[$];

    tetris_input_ctrl #(
        .ADC_W(ADC_W), .HI_THRESH(2000), .LO_THRESH(1300), .HYST(100),
        .DEBOUNCE_CYCLES(4), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .COMBO_CYCLES(6)
    ) dut (
        .clk(clk), .reset(reset), .adc_value(adc_value), .adc_valid(adc_valid),
        .btn_raw(btn_raw), .move_left(move_left), .move_right(move_right),
        .move_down(move_down), .rotate(rotate), .dir_state(dir_state),
        .btn_level(btn_level), .combo_reset(combo_reset)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            K_LEFT:  return "move_left";
            K_RIGHT: return "move_right";
            K_DOWN:  return "move_down";
            K_ROT:   return "rotate";
            default: return "combo_reset";
        endcase
    endfunction

    function automatic int q_size(input int k);
        case (k)
            K_LEFT:  return q_left.size();
            K_RIGHT: return q_right.size();
            K_DOWN:  return q_down.size();
            K_ROT:   return q_rot.size();
            default: return q_combo.size();
        endcase
    endfunction

    function automatic int q_front(input int k);
        case (k)
            K_LEFT:  return q_left[0];
            K_RIGHT: return q_right[0];
            K_DOWN:  return q_down[0];
            K_ROT:   return q_rot[0];
            default: return q_combo[0];
        endcase
    endfunction

    task automatic q_push(input int k, input int c);
        case (k)
            K_LEFT:  q_left.push_back(c);
            K_RIGHT: q_right.push_back(c);
            K_DOWN:  q_down.push_back(c);
            K_ROT:   q_rot.push_back(c);
            default: q_combo.push_back(c);
        endcase
    endtask

    task automatic q_pop(input int k, output int c);
        case (k)
            K_LEFT:  c = q_left.pop_front();
            K_RIGHT: c = q_right.pop_front();
            K_DOWN:  c = q_down.pop_front();
            K_ROT:   c = q_rot.pop_front();
            default: c = q_combo.pop_front();
        endcase
    endtask

    // Entry pulse at 'first', then +DAS, then every ARR, up to 'last'.
    task automatic push_rpt(input int k, input int first, input int last);
        int c;
        q_push(k, first);
        c = first + DAS;
        while (c <= last) begin
            q_push(k, c);
            c += ARR;
        end
    endtask

    task automatic mon_pulse(input int k, input logic val);
        int e;
        if (val) begin
            if (q_size(k) == 0) begin
                check({kname(k), "_unexpected"}, cyc, -1);
            end else begin
                q_pop(k, e);
                check({kname(k), "_cycle"}, cyc, e);
            end
        end else if (q_size(k) != 0 && q_front(k) < cyc) begin
            q_pop(k, e);
            check({kname(k), "_missing"}, -1, e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_pulse(K_LEFT, move_left);
            mon_pulse(K_RIGHT, move_right);
            mon_pulse(K_DOWN, move_down);
            mon_pulse(K_ROT, rotate);
            mon_pulse(K_COMBO, combo_reset);
            check("lr_exclusive", int'(move_left & move_right), 0);
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic strobe(input int v);
        adc_value = ADC_W'(v);
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset     = 1'b1;
        adc_value = '0;
        adc_valid = 1'b0;
        btn_raw   = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_dir", int'(dir_state), 0);
        check("rst_btn_level", int'(btn_level), 0);
        check("rst_pulses", int'({move_left, move_right, move_down, rotate, combo_reset}), 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Right tilt held, hysteresis hold at 1950, exit at 1890.
        t = cyc;
        push_rpt(K_RIGHT, t + 1, t + 24);
        strobe(2100);
        check("right_entry_dir", int'(dir_state), 2);
        at_cycle(t + 20);
        strobe(1950);
        check("right_hyst_hold", int'(dir_state), 2);
        at_cycle(t + 24);
        strobe(1890);
        check("right_exit_center", int'(dir_state), 0);
        at_cycle(t + 40);

        // Exact thresholds do not leave CENTER.
        strobe(2000);
        check("hi_thresh_equal", int'(dir_state), 0);
        strobe(1300);
        check("lo_thresh_equal", int'(dir_state), 0);

        // RIGHT -> LEFT swap, LEFT hysteresis edge, exit.
        t = cyc;
        push_rpt(K_RIGHT, t + 1, t + 10);
        strobe(2100);
        at_cycle(t + 10);
        push_rpt(K_LEFT, t + 11, t + 25);
        strobe(1200);
        check("swap_left_dir", int'(dir_state), 1);
        at_cycle(t + 20);
        strobe(1400);
        check("left_hyst_hold", int'(dir_state), 1);
        at_cycle(t + 25);
        strobe(1500);
        check("left_exit_center", int'(dir_state), 0);
        at_cycle(t + 40);

        // Rotate: 3-cycle glitch rejected, long press gives one pulse.
        t = cyc;
        btn_raw[0] = 1'b1;
        at_cycle(t + 3);
        btn_raw[0] = 1'b0;
        at_cycle(t + 12);
        check("glitch_btn_level", int'(btn_level), 0);
        t = cyc;
        q_push(K_ROT, t + 7);
        btn_raw[0] = 1'b1;
        at_cycle(t + 6);
        check("rot_btn_level", int'(btn_level), 1);
        at_cycle(t + 10);
        btn_raw[0] = 1'b0;
        at_cycle(t + 25);
        check("rot_release_level", int'(btn_level), 0);

        // Soft drop held: rising-edge pulse, DAS, then ARR until release.
        t = cyc;
        push_rpt(K_DOWN, t + 7, t + 35);
        btn_raw[1] = 1'b1;
        at_cycle(t + 29);
        btn_raw[1] = 1'b0;
        at_cycle(t + 34);
        check("down_level_held", int'(btn_level[1]), 1);
        at_cycle(t + 35);
        check("down_level_released", int'(btn_level[1]), 0);
        at_cycle(t + 50);

        // Both buttons plus right tilt, then reset mid-hold with a competing strobe.
        t = cyc;
        push_rpt(K_RIGHT, t + 1, t + 16);
`ifdef TETRIS_COMBO_RESET_EN
        q_push(K_COMBO, t + 12);
`else
        q_push(K_ROT, t + 7);
        push_rpt(K_DOWN, t + 7, t + 16);
`endif
        btn_raw = 2'b11;
        strobe(2100);
        at_cycle(t + 8);
        check("both_btn_level", int'(btn_level), 3);
        at_cycle(t + 16);
        reset     = 1'b1;
        btn_raw   = 2'b00;
        adc_value = ADC_W'(1200);
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        check("mid_rst_dir", int'(dir_state), 0);
        check("mid_rst_btn_level", int'(btn_level), 0);
        check("mid_rst_pulses", int'({move_left, move_right, move_down, rotate, combo_reset}), 0);
        @(negedge clk);
        reset = 1'b0;
        at_cycle(t + 30);
        check("post_rst_dir", int'(dir_state), 0);

        check("left_queue_drained", q_left.size(), 0);
        check("right_queue_drained", q_right.size(), 0);
        check("down_queue_drained", q_down.size(), 0);
        check("rot_queue_drained", q_rot.size(), 0);
        check("combo_queue_drained", q_combo.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
